// File: rtl/uart_rx_controller_if.sv
// Host-side bundle of the UART receiver: baud strobe, enable and serial line in;
// received byte, status flags and busy out.
interface uart_rx_controller_if;
    logic       sampleEnable;
    logic       rxEnable;
    logic       rxD;
    logic [7:0] rxData;
    logic       rxValid;
    logic       parityError;
    logic       frameError;
    logic       rxBusy;

    modport slave (
        input  sampleEnable, rxEnable, rxD,
        output rxData, rxValid, parityError, frameError, rxBusy
    );

    modport master (
        output sampleEnable, rxEnable, rxD,
        input  rxData, rxValid, parityError, frameError, rxBusy
    );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: oversampled start qualification, 8N data LSB-first,
// even-parity check, stop-bit check and break suppression.
module uart_rx_controller #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_controller_if.slave  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_WAIT_HIGH = 3'd6;

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_bit_q, parity_bit_d;
    logic          stop_bit_q, stop_bit_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          line;
    logic          se;

    assign line = sync2_q;
    assign se   = bus.sampleEnable;

    always_comb begin
        sync1_d      = bus.rxD;
        sync2_d      = sync1_q;
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        stop_bit_d   = stop_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            S_IDLE: begin
                if (se && !line) begin
                    state_d      = S_START;
                    sample_cnt_d = '0;
                end
            end
            S_START: begin
                if (se) begin
                    if (sample_cnt_q == HALF_M1) begin
                        // Half a bit in: still low means a real start bit.
                        state_d      = line ? S_IDLE : S_DATA;
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (se) begin
                    if (sample_cnt_q == LAST) begin
                        sample_cnt_d = '0;
                        if (state_q == S_DATA) begin
                            shift_d[bit_cnt_q] = line;
                            bit_cnt_d          = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                        end else if (state_q == S_PARITY) begin
                            parity_bit_d = line;
                            state_d      = S_STOP;
                        end else begin
                            stop_bit_d = line;
                            state_d    = S_DONE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                rx_data_d    = shift_q;
                parity_err_d = parity_bit_q ^ (^shift_q);
                frame_err_d  = ~stop_bit_q;
                rx_valid_d   = 1'b1;
                state_d      = stop_bit_q ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must go high before a new frame can start.
                if (se && line) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Disabling aborts any frame in flight, except one already being delivered.
        if (!bus.rxEnable && state_q != S_DONE) begin
            state_d      = S_IDLE;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
            rx_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            stop_bit_q   <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            stop_bit_q   <= stop_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.rxData      = rx_data_q;
    assign bus.rxValid     = rx_valid_q;
    assign bus.parityError = parity_err_q;
    assign bus.frameError  = frame_err_q;
    assign bus.rxBusy      = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side sequencer for the UART link. It oversamples the serial line, detects and qualifies the start bit, and shifts in 8 data bits LSB-first. It then feeds the assembled byte to the receive parity calculator (even parity: expected bit = XOR of data bits), checks the received parity and stop bits, and presents the byte with status flags to the host side. It sits between the baud-rate generator's sample strobe and the RX data register consumer.

## Interface
- OVERSAMPLE, 16: sample strobes per bit period; must be even and ≥ 4.
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-low; clears all state and outputs.
- sampleEnable  in  1  one-clk pulse at OVERSAMPLE × baud from the baud generator.
- rxEnable  in  1  receiver enable; 0 aborts any frame and holds IDLE.
- rxD  in  1  asynchronous serial line, idle high.
- rxData  out  8  last received byte; held until next rxValid.
- rxValid  out  1  one-clk pulse: rxData, parityError and frameError are updated.
- parityError  out  1  received parity ≠ computed parity; updated with rxValid.
- frameError  out  1  stop bit sampled 0; updated with rxValid.
- rxBusy  out  1  high in every state except IDLE and WAIT_HIGH.

## Operation
- rxD passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- sampleCnt (log2 OVERSAMPLE bits) and bitCnt (3 bits) advance only on clk edges with sampleEnable=1.
- States:
  - IDLE: on a strobe with line=0 → START, sampleCnt=0.
  - START: at sampleCnt = OVERSAMPLE/2−1, re-sample. A 0 goes → DATA, sampleCnt=0, bitCnt=0. A 1 is a glitch → IDLE, with no output activity.
  - DATA: at sampleCnt = OVERSAMPLE−1 (mid-bit), shift the line into shiftReg[bitCnt] (LSB first) and reset sampleCnt. After bitCnt=7 → PARITY.
  - PARITY: at the mid-bit strobe, capture rxParity → STOP.
  - STOP: at the mid-bit strobe, capture the stop bit → DONE.
  - DONE (one clk, independent of sampleEnable): load rxData=shiftReg; set parityError = rxParity XOR (^shiftReg) and frameError = ~stopBit; pulse rxValid. Go → WAIT_HIGH if stopBit=0, else → IDLE.
  - WAIT_HIGH: remain until a strobe samples line=1 → IDLE. This prevents a break (line held low) from re-triggering frames.
- rxEnable=0 in any state: → IDLE next clk, counters cleared, no rxValid, and outputs keep their previous values. rxEnable is ignored in DONE (a completed frame is always delivered).
- Data with a parity or frame error is still delivered. The consumer decides whether to discard it.

## Timing
- Reset values: rxData=8'h00, rxValid=0, parityError=0, frameError=0, rxBusy=0; state=IDLE, synchronizer flops=1.
- Start detection latency: up to 2 clk (synchronizer) + 1 strobe period.
- rxValid asserts on the clk after the strobe that samples the stop bit mid-bit, and lasts exactly 1 clk.
- From the first strobe seeing the start bit low to rxValid: (OVERSAMPLE/2) + 10·OVERSAMPLE strobes, +1 clk.
- The next start bit may be detected on the first strobe after returning to IDLE, so back-to-back frames need no extra idle time.
- sampleEnable coinciding with the DONE clk is ignored.
- Reset mid-frame: all outputs take reset values on the next edge and no rxValid is emitted.

## Test plan
- Frame 0xA5, parity 0, stop 1, OVERSAMPLE=16 → one rxValid pulse with rxData=0xA5, parityError=0, frameError=0, occurring 168 strobes + 1 clk after the start edge.
- Frame 0x07, parity bit sent as 0 (should be 1) → rxData=0x07, parityError=1, frameError=0.
- Frame 0x3C, parity 0, stop 0, then line held low for 3 bit times → rxValid with frameError=1 and no further rxValid until the line returns high and a new start bit is received.
- Line low for 4 strobes then high → state returns to IDLE, no rxValid, rxBusy high only during the glitch.
- Two back-to-back frames 0x55 and 0xFF with no idle gap → two rxValid pulses, rxData 0x55 then 0xFF, both with parityError=0 and frameError=0.
- reset=0 (or rxEnable=0) asserted during data bit 4 of 0x81, then released and a clean 0x81 sent → no pulse from the aborted frame; the clean frame yields rxData=0x81, parityError=0.
